fft_stream_responder: RTL and testbench

FFT_STREAM_RESPONDER -- requirements
Module: fft_stream_responder

---
 rtl/fft_resp_pkg.sv | 17 +
 rtl/fft_resp_buffer.sv | 25 ++
 rtl/fft_stream_responder.sv | 148 ++++++++++++++
 tb/tb_fft_stream_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_resp_pkg.sv
// rtl/fft_resp_pkg.sv - shared state encoding and field positions for the FFT stream responder
package fft_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  localparam int FIELD_W       = 32;
  localparam int POINT_W       = 64;
  localparam int RE_LSB        = 0;
  localparam int IM_LSB        = 32;
  localparam int CFG_FWD_BIT   = 0;
  localparam int CFG_SHIFT_LSB = 1;

endpackage

// File: rtl/fft_resp_buffer.sv
// rtl/fft_resp_buffer.sv - N x 64 simple dual-port frame buffer with registered read
module fft_resp_buffer
  import fft_resp_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = POINT_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // rd_data holds while rd_en is low so the output stage can stall on it
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_stream_responder.sv
// rtl/fft_stream_responder.sv - buffers an N-point frame and replays it scaled/conjugated
// Optional build macro FFT_RESP_BITREV_EN: replay in bit-reversed index order.
module fft_stream_responder
  import fft_resp_pkg::*;
#(
  parameter int NFFT            = 3,
  parameter int SCALE_SCH_WIDTH = 4,
  parameter int CONFIG_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_axis_c_tvalid,
  output logic                    s_axis_c_tready,
  input  logic                    s_axis_c_tlast,
  input  logic [CONFIG_WIDTH-1:0] s_axis_c_tdata,
  input  logic                    s_axis_i_tvalid,
  output logic                    s_axis_i_tready,
  input  logic                    s_axis_i_tlast,
  input  logic [POINT_W-1:0]      s_axis_i_tdata,
  output logic                    m_axis_o_tvalid,
  input  logic                    m_axis_o_tready,
  output logic                    m_axis_o_tlast,
  output logic [POINT_W-1:0]      m_axis_o_tdata,
  output logic                    event_tlast_unexpected,
  output logic                    event_tlast_missing,
  output logic                    busy
);

  localparam int             CFG_W    = SCALE_SCH_WIDTH + 1;
  localparam logic [NFFT:0]  LAST_IDX = (NFFT+1)'((1 << NFFT) - 1);
  localparam logic [NFFT:0]  CNT_ONE  = (NFFT+1)'(1);

  state_t            state;
  logic [NFFT:0]     cnt;
  logic [CFG_W-1:0]  cfg_pending, cfg_frame, cfg_next;
  logic              rd_valid, rd_last;
  logic [NFFT-1:0]   rd_addr;
  logic [POINT_W-1:0] rd_data, out_point;
  logic              c_hs, i_hs, out_adv, issue, load_out;
  logic signed [FIELD_W-1:0] re_in, im_in, im_sel;
  logic [SCALE_SCH_WIDTH-1:0] shift;

  wire unused_cfg = ^{s_axis_c_tdata[CONFIG_WIDTH-1:CFG_W], s_axis_c_tlast};

  assign s_axis_c_tready = (state == S_IDLE);
  assign s_axis_i_tready = (state != S_UNLOAD);
  assign busy            = (state != S_IDLE);

  assign c_hs     = s_axis_c_tvalid && s_axis_c_tready;
  assign i_hs     = s_axis_i_tvalid && s_axis_i_tready;
  assign cfg_next = c_hs ? s_axis_c_tdata[CFG_W-1:0] : cfg_pending;

  // Read issue runs one beat ahead of the output register; both stall together
  assign out_adv  = !m_axis_o_tvalid || m_axis_o_tready;
  assign issue    = (state == S_UNLOAD) && !cnt[NFFT] && (!rd_valid || out_adv);
  assign load_out = rd_valid && out_adv;

  always_comb begin
    rd_addr = cnt[NFFT-1:0];
`ifdef FFT_RESP_BITREV_EN
    for (int b = 0; b < NFFT; b++) rd_addr[b] = cnt[NFFT-1-b];
`endif
  end

  always_comb begin
    re_in  = rd_data[RE_LSB +: FIELD_W];
    im_in  = rd_data[IM_LSB +: FIELD_W];
    shift  = cfg_frame[CFG_SHIFT_LSB +: SCALE_SCH_WIDTH];
    im_sel = cfg_frame[CFG_FWD_BIT] ? im_in : -im_in;
    out_point = '0;
    out_point[RE_LSB +: FIELD_W] = re_in >>> shift;
    out_point[IM_LSB +: FIELD_W] = im_sel >>> shift;
  end

  fft_resp_buffer #(.ADDR_W(NFFT), .DATA_W(POINT_W)) u_buffer (
    .clk     (clk),
    .wr_en   (i_hs),
    .wr_addr (cnt[NFFT-1:0]),
    .wr_data (s_axis_i_tdata),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                  <= S_IDLE;
      cnt                    <= '0;
      cfg_pending            <= CFG_W'(1);
      cfg_frame              <= CFG_W'(1);
      rd_valid               <= 1'b0;
      rd_last                <= 1'b0;
      m_axis_o_tvalid        <= 1'b0;
      m_axis_o_tlast         <= 1'b0;
      m_axis_o_tdata         <= '0;
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;
    end else begin
      event_tlast_unexpected <= i_hs && s_axis_i_tlast && (cnt != LAST_IDX);
      event_tlast_missing    <= i_hs && !s_axis_i_tlast && (cnt == LAST_IDX);
      case (state)
        S_IDLE: begin
          cfg_pending <= cfg_next;
          if (i_hs) begin
            cfg_frame <= cfg_next;
            cnt       <= CNT_ONE;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_hs) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= S_UNLOAD;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        S_UNLOAD: begin
          if (issue) begin
            cnt      <= cnt + CNT_ONE;
            rd_valid <= 1'b1;
            rd_last  <= (cnt == LAST_IDX);
          end else if (out_adv) begin
            rd_valid <= 1'b0;
          end
          if (load_out) begin
            m_axis_o_tvalid <= 1'b1;
            m_axis_o_tdata  <= out_point;
            m_axis_o_tlast  <= rd_last;
          end else if (m_axis_o_tready) begin
            m_axis_o_tvalid <= 1'b0;
          end
          if (m_axis_o_tvalid && m_axis_o_tready && m_axis_o_tlast) begin
            m_axis_o_tvalid <= 1'b0;
            m_axis_o_tlast  <= 1'b0;
            rd_valid        <= 1'b0;
            cnt             <= '0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_responder.sv
// tb/tb_fft_stream_responder.sv - randomized directed bench with an arithmetic reference model
module tb_fft_stream_responder;

  localparam int NFFT = 3;
  localparam int N    = 1 << NFFT;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_axis_c_tvalid = 1'b0, s_axis_c_tlast = 1'b0, s_axis_c_tready;
  logic [7:0]  s_axis_c_tdata = '0;
  logic        s_axis_i_tvalid = 1'b0, s_axis_i_tlast = 1'b0, s_axis_i_tready;
  logic [63:0] s_axis_i_tdata = '0;
  logic        m_axis_o_tvalid, m_axis_o_tready = 1'b0, m_axis_o_tlast;
  logic [63:0] m_axis_o_tdata;
  logic        event_tlast_unexpected, event_tlast_missing, busy;

  always #5 clk = ~clk;

  fft_stream_responder #(.NFFT(NFFT), .SCALE_SCH_WIDTH(4), .CONFIG_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_c_tvalid(s_axis_c_tvalid), .s_axis_c_tready(s_axis_c_tready),
    .s_axis_c_tlast(s_axis_c_tlast), .s_axis_c_tdata(s_axis_c_tdata),
    .s_axis_i_tvalid(s_axis_i_tvalid), .s_axis_i_tready(s_axis_i_tready),
    .s_axis_i_tlast(s_axis_i_tlast), .s_axis_i_tdata(s_axis_i_tdata),
    .m_axis_o_tvalid(m_axis_o_tvalid), .m_axis_o_tready(m_axis_o_tready),
    .m_axis_o_tlast(m_axis_o_tlast), .m_axis_o_tdata(m_axis_o_tdata),
    .event_tlast_unexpected(event_tlast_unexpected), .event_tlast_missing(event_tlast_missing),
    .busy(busy)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_unexp = 0, n_miss = 0;
  int last_in_cyc, first_out_cyc, rx_n, u0, m0;
  logic [7:0]  cur_cfg;
  logic [N-1:0] mask;
  logic [63:0] frame [N];
  logic [63:0] exp_q [N];
  logic [63:0] rx [N];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (event_tlast_unexpected) n_unexp <= n_unexp + 1;
    if (event_tlast_missing)    n_miss  <= n_miss + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] p, input logic [7:0] c);
    int re, im, sh;
    re = p[31:0];
    im = p[63:32];
    sh = c[4:1];
    if (!c[0]) im = -im;
    re = re >>> sh;
    im = im >>> sh;
    return {im, re};
  endfunction

  function automatic int order(input int k);
    int r = k;
`ifdef FFT_RESP_BITREV_EN
    r = 0;
    for (int b = 0; b < NFFT; b++) r = r * 2 + ((k >> b) & 1);
`endif
    return r;
  endfunction

  task automatic send_config(input logic [7:0] c);
    int guard = 0;
    s_axis_c_tvalid = 1'b1;
    s_axis_c_tdata  = c;
    while (!s_axis_c_tready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    s_axis_c_tvalid = 1'b0;
    cur_cfg = c;
  endtask

  task automatic send_frame(input logic use_cfg, input logic [7:0] c);
    if (use_cfg) cur_cfg = c;
    for (int k = 0; k < N; k++) exp_q[k] = model(frame[order(k)], cur_cfg);
    u0 = n_unexp;
    m0 = n_miss;
    for (int k = 0; k < N; k++) begin
      int guard = 0;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      s_axis_i_tvalid = 1'b1;
      s_axis_i_tdata  = frame[k];
      s_axis_i_tlast  = mask[k];
      if (k == 0 && use_cfg) begin s_axis_c_tvalid = 1'b1; s_axis_c_tdata = c; end
      while (!s_axis_i_tready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      s_axis_c_tvalid = 1'b0;
      s_axis_i_tvalid = 1'b0;
      check("ev_unexpected_pulse", event_tlast_unexpected, mask[k] && k != N-1);
      check("ev_missing_pulse", event_tlast_missing, !mask[k] && k == N-1);
      if (k == 0) begin
        check("load_c_tready", s_axis_c_tready, 0);
        check("load_busy", busy, 1);
      end
    end
    last_in_cyc = cyc;
  endtask

  task automatic collect(input logic stall, input int stop_at);
    int iter = 0;
    logic prev_stall = 1'b0, held_last = 1'b0;
    logic [63:0] held = '0;
    first_out_cyc = -1;
    rx_n = 0;
    while (rx_n < stop_at && iter < 200) begin
      if (m_axis_o_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
      if (prev_stall) begin
        check("stall_valid", m_axis_o_tvalid, 1);
        check("stall_data", m_axis_o_tdata, held);
        check("stall_last", m_axis_o_tlast, held_last);
      end
      m_axis_o_tready = stall ? ((iter % 4 == 0) || (iter % 4 == 3)) : 1'b1;
      if (m_axis_o_tvalid && m_axis_o_tready) begin
        check($sformatf("out_data[%0d]", rx_n), m_axis_o_tdata, exp_q[rx_n]);
        check($sformatf("out_last[%0d]", rx_n), m_axis_o_tlast, rx_n == N-1);
        rx[rx_n] = m_axis_o_tdata;
        rx_n++;
      end
      prev_stall = m_axis_o_tvalid && !m_axis_o_tready;
      held       = m_axis_o_tdata;
      held_last  = m_axis_o_tlast;
      iter++;
      @(posedge clk); #1;
    end
    m_axis_o_tready = 1'b0;
    check("beats_received", rx_n, stop_at);
  endtask

  task automatic finish_frame(input int exp_unexp, input int exp_miss);
    check("idle_busy", busy, 0);
    check("idle_tvalid", m_axis_o_tvalid, 0);
    check("idle_i_tready", s_axis_i_tready, 1);
    check("count_unexpected", n_unexp - u0, exp_unexp);
    check("count_missing", n_miss - m0, exp_miss);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) frame[k] = {$urandom, $urandom};
  endtask

  initial begin
    cur_cfg = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_o_tvalid, 0);
    check("rst_tdata", m_axis_o_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_events", {event_tlast_unexpected, event_tlast_missing}, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_c_tready", s_axis_c_tready, 1);

    // forward, no scaling: pass-through with exact latency
    for (int k = 0; k < N; k++) frame[k] = {32'(-k), 32'(k)};
    mask = 8'h80;
    send_config(8'h01);
    send_frame(1'b0, 8'h00);
    collect(1'b0, N);
    check("first_valid_latency", first_out_cyc - last_in_cyc, 2);
    finish_frame(0, 0);

    // inverse, shift 2
    for (int k = 0; k < N; k++) frame[k] = {32'h40, 32'h100};
    send_config(8'h04);
    send_frame(1'b0, 8'h00);
    collect(1'b0, N);
    check("inverse_shift2", rx[0], 64'hFFFFFFF0_00000040);
    finish_frame(0, 0);

    // misplaced tlast: early on beat 3, absent on beat 7
    rand_frame();
    mask = 8'h08;
    send_frame(1'b0, 8'h00);
    collect(1'b0, N);
    finish_frame(1, 1);

    // config accepted alongside first beat overrides the pending word; stalled output
    for (int r = 0; r < 3; r++) begin
      rand_frame();
      mask = 8'h80;
      send_config(8'h05);
      send_frame(1'b1, 8'($urandom_range(0, 31)));
      collect(1'b1, N);
      finish_frame(0, 0);
    end

    // negation wrap of the most negative value
    rand_frame();
    frame[0] = {32'h80000000, 32'h7FFFFFFF};
    send_frame(1'b1, 8'h00);
    collect(1'b1, N);
    check("neg_wrap", rx[0], 64'h80000000_7FFFFFFF);
    finish_frame(0, 0);

    // reset while output beat 4 is presented
    rand_frame();
    send_frame(1'b1, 8'h03);
    collect(1'b1, 4);
    check("beat4_presented", m_axis_o_tvalid, 1);
    resetn = 1'b0;
    #1;
    check("arst_tvalid", m_axis_o_tvalid, 0);
    check("arst_tlast", m_axis_o_tlast, 0);
    check("arst_tdata", m_axis_o_tdata, 0);
    check("arst_busy", busy, 0);
    check("arst_events", {event_tlast_unexpected, event_tlast_missing}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    cur_cfg = 8'h01;
    for (int r = 0; r < 2; r++) begin
      rand_frame();
      send_frame(1'b0, 8'h00);
      collect(r == 1, N);
      finish_frame(0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
